// File: rtl/key_schedule_if.sv
// Start/read bus between the AES-128 key-schedule controller and its consumer.
// The master starts expansions and reads round keys; the slave is the controller.
interface key_schedule_if;
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         key_ready;
  logic         rd_en;
  logic [3:0]   rd_addr;
  logic [127:0] rd_data;

  modport master (
    output start, key_in, rd_en, rd_addr,
    input  busy, key_ready, rd_data
  );

  modport slave (
    input  start, key_in, rd_en, rd_addr,
    output busy, key_ready, rd_data
  );
endinterface

// File: rtl/key_schedule_ctrl.sv
// Iterative AES-128 key expansion: one round key per clock into an 11-slot bank,
// with a registered read port for encrypt or decrypt ordering.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   S_IDLE   | no valid schedule; waiting for start
//   S_EXPAND | generating round key rnd_q into slot rnd_q; start ignored
//   S_READY  | slots 0..10 hold the schedule of the last accepted key
module key_schedule_ctrl #(
  parameter int NR = 10,
  parameter int KW = 128
) (
  input  logic           clk,
  input  logic           rst_n,
  key_schedule_if.slave  bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_EXPAND = 2'd1;
  localparam logic [1:0] S_READY  = 2'd2;
  localparam logic [3:0] LAST_RND = 4'(NR);

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    sub_byte = SBOX[2047 - 8 * int'(b) -: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  logic [1:0]    state_q, state_d;
  logic [3:0]    rnd_q, rnd_d;
  logic [KW-1:0] work_q, work_d;
  logic [KW-1:0] bank_q [0:10];
  logic [KW-1:0] rd_data_q;

  logic          wr_en;
  logic [3:0]    wr_addr;
  logic [KW-1:0] wr_data;

  logic [31:0]   rot_w3;
  logic [31:0]   t_word;
  logic [31:0]   nw0, nw1, nw2, nw3;
  logic [KW-1:0] next_key;

  always_comb begin
    rot_w3   = {work_q[23:0], work_q[31:24]};
    t_word   = {sub_byte(rot_w3[31:24]), sub_byte(rot_w3[23:16]),
                sub_byte(rot_w3[15:8]),  sub_byte(rot_w3[7:0])}
               ^ {rcon(rnd_q), 24'h0};
    nw0      = work_q[127:96] ^ t_word;
    nw1      = work_q[95:64]  ^ nw0;
    nw2      = work_q[63:32]  ^ nw1;
    nw3      = work_q[31:0]   ^ nw2;
    next_key = {nw0, nw1, nw2, nw3};
  end

  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    work_d  = work_q;
    wr_en   = 1'b0;
    wr_addr = 4'd0;
    wr_data = next_key;
    case (state_q)
      S_IDLE, S_READY: begin
        if (bus.start) begin
          state_d = S_EXPAND;
          rnd_d   = 4'd1;
          work_d  = bus.key_in;
          wr_en   = 1'b1;
          wr_addr = 4'd0;
          wr_data = bus.key_in;
        end
      end
      S_EXPAND: begin
        wr_en   = 1'b1;
        wr_addr = rnd_q;
        work_d  = next_key;
        if (rnd_q == LAST_RND) begin
          state_d = S_READY;
          rnd_d   = 4'd0;
        end else begin
          rnd_d   = rnd_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rnd_q   <= 4'd0;
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      work_q  <= work_d;
    end
  end

  // Nonblocking update gives read-before-write when a slot is read as it is written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 11; i++) bank_q[i] <= '0;
      rd_data_q <= '0;
    end else begin
      if (wr_en) bank_q[wr_addr] <= wr_data;
      if (bus.rd_en) rd_data_q <= (bus.rd_addr <= 4'd10) ? bank_q[bus.rd_addr] : '0;
    end
  end

  assign bus.busy      = (state_q == S_EXPAND);
  assign bus.key_ready = (state_q == S_READY);
  assign bus.rd_data   = rd_data_q;

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Bench for key_schedule_ctrl: a word-level FIPS-197 key-expansion model (S-box
// derived from GF(2^8) inversion) compared against the controller's bank and flags.
module tb_key_schedule_ctrl;

  localparam logic [127:0] FIPS_KEY   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_R1    = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_R10   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] SEQ_KEY    = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] SEQ_R10    = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  key_schedule_if bus ();
  key_schedule_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]   sb [256];
  logic [127:0] exp_sched [11];

  function automatic logic [7:0] xtime(input logic [7:0] a);
    xtime = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = xtime(aa);
      bb = bb >> 1;
    end
    gmul = p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    rotl8 = 8'((b << n) | (b >> (8 - n)));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0)
        for (int y = 1; y < 256; y++)
          if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // Classic 44-word expansion: w[i] = w[i-4] ^ temp.
  task automatic expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] temp;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      temp = w[i-1];
      if (i % 4 == 0) begin
        temp = {temp[23:0], temp[31:24]};
        temp = {sb[temp[31:24]], sb[temp[23:16]], sb[temp[15:8]], sb[temp[7:0]]} ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ temp;
    end
    for (int r = 0; r < 11; r++) exp_sched[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [3:0] a, output logic [127:0] d);
    bus.rd_en = 1'b1;
    bus.rd_addr = a;
    tick();
    bus.rd_en = 1'b0;
    d = bus.rd_data;
  endtask

  task automatic start_key(input logic [127:0] k);
    bus.start = 1'b1;
    bus.key_in = k;
    tick();
    bus.start = 1'b0;
    bus.key_in = '0;
  endtask

  task automatic test_reset();
    logic [127:0] d;
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b expected 0", bus.busy); end
    vectors++; if (bus.key_ready !== 1'b0) begin miscompares++; $display("FAIL rst_ready: got %b expected 0", bus.key_ready); end
    vectors++; if (bus.rd_data !== '0) begin miscompares++; $display("FAIL rst_rd_data: got %h expected 0", bus.rd_data); end
    start_key(FIPS_KEY);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL rst_mid_busy: got %b expected 0", bus.busy); end
    vectors++; if (bus.key_ready !== 1'b0) begin miscompares++; $display("FAIL rst_mid_ready: got %b expected 0", bus.key_ready); end
    tick();
    rst_n = 1'b1;
    tick();
    for (int a = 0; a < 11; a++) begin
      rd(4'(a), d);
      vectors++; if (d !== '0) begin miscompares++; $display("FAIL rst_slot%0d: got %h expected 0", a, d); end
    end
    vectors++; if (bus.key_ready !== 1'b0) begin miscompares++; $display("FAIL rst_ready_after: got %b expected 0", bus.key_ready); end
  endtask

  task automatic test_fips();
    logic [127:0] d;
    expand(FIPS_KEY);
    start_key(FIPS_KEY);
    vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL fips_busy_e0: got %b expected 1", bus.busy); end
    for (int r = 1; r <= 10; r++) begin
      tick();
      vectors++;
      if (bus.busy !== (r < 10) || bus.key_ready !== (r == 10)) begin
        miscompares++;
        $display("FAIL fips_flags_e%0d: got busy=%b ready=%b expected busy=%b ready=%b", r, bus.busy, bus.key_ready, r < 10, r == 10);
      end
    end
    rd(4'd1, d);
    vectors++; if (d !== FIPS_R1) begin miscompares++; $display("FAIL fips_slot1: got %h expected %h", d, FIPS_R1); end
    rd(4'd10, d);
    vectors++; if (d !== FIPS_R10) begin miscompares++; $display("FAIL fips_slot10: got %h expected %h", d, FIPS_R10); end
    for (int a = 0; a < 11; a++) begin
      rd(4'(a), d);
      vectors++; if (d !== exp_sched[a]) begin miscompares++; $display("FAIL fips_model_slot%0d: got %h expected %h", a, d, exp_sched[a]); end
    end
  endtask

  task automatic test_ignored_start();
    logic [127:0] d;
    expand(FIPS_KEY);
    start_key(FIPS_KEY);
    for (int r = 1; r <= 10; r++) begin
      if (r == 4) begin bus.start = 1'b1; bus.key_in = '0; end
      tick();
      bus.start = 1'b0;
    end
    vectors++; if (bus.key_ready !== 1'b1) begin miscompares++; $display("FAIL ign_ready: got %b expected 1", bus.key_ready); end
    rd(4'd10, d);
    vectors++; if (d !== FIPS_R10) begin miscompares++; $display("FAIL ign_slot10: got %h expected %h", d, FIPS_R10); end
    rd(4'd0, d);
    vectors++; if (d !== FIPS_KEY) begin miscompares++; $display("FAIL ign_slot0: got %h expected %h", d, FIPS_KEY); end
  endtask

  task automatic test_rekey();
    logic [127:0] old_sched [11];
    logic [127:0] d;
    for (int a = 0; a < 11; a++) old_sched[a] = exp_sched[a];
    expand(SEQ_KEY);
    start_key(SEQ_KEY);
    vectors++; if (bus.key_ready !== 1'b0 || bus.busy !== 1'b1) begin miscompares++; $display("FAIL rekey_accept: got busy=%b ready=%b expected busy=1 ready=0", bus.busy, bus.key_ready); end
    for (int k = 1; k <= 10; k++) begin
      bus.rd_en = 1'b1;
      bus.rd_addr = 4'(k);
      tick();
      vectors++; if (bus.rd_data !== old_sched[k]) begin miscompares++; $display("FAIL rbw_slot%0d: got %h expected %h", k, bus.rd_data, old_sched[k]); end
    end
    bus.rd_en = 1'b0;
    vectors++; if (bus.key_ready !== 1'b1) begin miscompares++; $display("FAIL rekey_ready: got %b expected 1", bus.key_ready); end
    rd(4'd10, d);
    vectors++; if (d !== SEQ_R10) begin miscompares++; $display("FAIL rekey_slot10: got %h expected %h", d, SEQ_R10); end
  endtask

  task automatic test_read_port();
    logic [127:0] held;
    logic         en;
    logic [3:0]   a;
    bus.rd_en = 1'b1;
    for (int i = 10; i >= 0; i--) begin
      bus.rd_addr = 4'(i);
      tick();
      vectors++; if (bus.rd_data !== exp_sched[i]) begin miscompares++; $display("FAIL desc_slot%0d: got %h expected %h", i, bus.rd_data, exp_sched[i]); end
    end
    bus.rd_addr = 4'd12;
    tick();
    vectors++; if (bus.rd_data !== '0) begin miscompares++; $display("FAIL rd_addr12: got %h expected 0", bus.rd_data); end
    bus.rd_addr = 4'd7;
    tick();
    bus.rd_en = 1'b0;
    bus.rd_addr = 4'd2;
    repeat (3) tick();
    vectors++; if (bus.rd_data !== exp_sched[7]) begin miscompares++; $display("FAIL rd_hold: got %h expected %h", bus.rd_data, exp_sched[7]); end
    held = exp_sched[7];
    for (int n = 0; n < 40; n++) begin
      en = 1'($urandom_range(0, 1));
      a = 4'($urandom_range(0, 15));
      bus.rd_en = en;
      bus.rd_addr = a;
      tick();
      if (en) held = (a <= 4'd10) ? exp_sched[a] : '0;
      vectors++; if (bus.rd_data !== held) begin miscompares++; $display("FAIL rand_rd%0d en=%b addr=%0d: got %h expected %h", n, en, a, bus.rd_data, held); end
    end
    bus.rd_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [127:0] k;
    logic [127:0] d;
    for (int n = 0; n < 3; n++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      expand(k);
      start_key(k);
      vectors++; if (bus.busy !== 1'b1 || bus.key_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_accept%0d: got busy=%b ready=%b expected busy=1 ready=0", n, bus.busy, bus.key_ready); end
      repeat (10) tick();
      vectors++; if (bus.key_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready%0d: got %b expected 1", n, bus.key_ready); end
    end
    for (int a = 0; a < 11; a++) begin
      rd(4'(a), d);
      vectors++; if (d !== exp_sched[a]) begin miscompares++; $display("FAIL b2b_slot%0d: got %h expected %h", a, d, exp_sched[a]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [127:0] d;
    start_key(SEQ_KEY);
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    vectors++; if (bus.busy !== 1'b0 || bus.key_ready !== 1'b0) begin miscompares++; $display("FAIL rmid_flags: got busy=%b ready=%b expected 0/0", bus.busy, bus.key_ready); end
    tick();
    rst_n = 1'b1;
    tick();
    for (int a = 0; a < 11; a++) begin
      rd(4'(a), d);
      vectors++; if (d !== '0) begin miscompares++; $display("FAIL rmid_clear%0d: got %h expected 0", a, d); end
    end
    expand(FIPS_KEY);
    start_key(FIPS_KEY);
    repeat (10) tick();
    vectors++; if (bus.key_ready !== 1'b1) begin miscompares++; $display("FAIL rmid_ready: got %b expected 1", bus.key_ready); end
    for (int a = 0; a < 11; a++) begin
      rd(4'(a), d);
      vectors++; if (d !== exp_sched[a]) begin miscompares++; $display("FAIL rmid_slot%0d: got %h expected %h", a, d, exp_sched[a]); end
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.key_in = '0;
    bus.rd_en = 1'b0;
    bus.rd_addr = 4'd0;
    build_sbox();
    test_reset();
    test_fips();
    test_ignored_start();
    test_rekey();
    test_read_port();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/key_schedule_ctrl.md
# key_schedule_ctrl

Iterative AES-128 key-schedule controller. It accepts a 128-bit cipher key through a start handshake and computes round keys 1..10 sequentially, one round per clock, with a single shared round-expansion datapath (RotWord, subByte, rcon). All 11 round keys are stored in an internal key bank. A registered read port serves them to the round datapath in either order, for encryption or decryption.

## Interface
- NR, 10: number of expansion rounds; fixed for AES-128.
- KW, 128: key and round-key width in bits.
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset; asserting 0 clears all state immediately.
- start  in  1  one-cycle request to expand key_in; accepted only when busy=0.
- key_in  in  128  cipher key, sampled on the accepting edge; [127:96] is word w0.
- busy  out  1  high while expansion is in progress.
- key_ready  out  1  high when slots 0..10 all hold the schedule of the last accepted key.
- rd_en  in  1  read strobe.
- rd_addr  in  4  round-key index, 0..10.
- rd_data  out  128  registered round key.

## Operation
- FSM states: IDLE, EXPAND, READY.
  - IDLE→EXPAND on start.
  - EXPAND→READY on the edge that writes slot 10.
  - READY→EXPAND on start, which re-keys.
  - In EXPAND, start is ignored; the key is not queued.
- Accepting edge:
  - slot0 ← key_in and working register ← key_in.
  - Round counter rnd ← 1; busy ← 1; key_ready ← 0.
- Each EXPAND edge, with K = working register, words w0..w3 = K[127:96]..K[31:0]:
  - t = subByte({w3[23:0], w3[31:24]}) ^ {rcon(rnd), 24'h0}.
  - w0' = w0^t, w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'.
  - slot[rnd] ← {w0',w1',w2',w3'}; working register ← same; rnd ← rnd+1.
- rcon(1..10) = 01,02,04,08,10,20,40,80,1B,36 (top byte).
- On the edge with rnd=10: state → READY, busy ← 0, key_ready ← 1, rnd ← 0.
- Read port, in every state:
  - rd_en=1 → rd_data ← slot[rd_addr] on the next edge.
  - rd_addr 11..15 → rd_data ← 0.
  - rd_en=0 → rd_data holds its value.
- Same-edge read and write to a slot returns the old contents (read-before-write).
- Reading during EXPAND is legal. Unwritten slots return stale data; consumers gate on key_ready.

## Timing
- Reset values:
  - state IDLE, busy 0, key_ready 0, rd_data 0, rnd 0.
  - Working register 0; all 11 slots 0.
- Latency: start accepted at edge E0 → slot r written at edge E0+r → busy falls and key_ready rises after edge E0+10. This gives a 10-cycle expansion with 11 total slot writes.
- Throughput: back-to-back re-key is possible. A start in the first cycle after key_ready rises is accepted.
- key_ready drops on the edge that accepts a new start. Slots 1..10 keep old-key contents until overwritten.
- Reset mid-EXPAND: immediate return to IDLE. The partial schedule is discarded, slots are cleared, and key_ready stays 0.
- rd_data read latency is 1 cycle, fixed. No combinational path from rd_addr to rd_data.
- rnd never exceeds 10; no wrap to 11..15 is reachable.

## Test plan
- Reset: assert reset=0 mid-expansion, release → busy=0, key_ready=0, rd_data=0, and all 11 slots read back 0.
- FIPS-197 expansion: key_in=2b7e151628aed2a6abf7158809cf4f3c with start=1 at E0.
  - key_ready rises after E0+10.
  - Slot1 reads a0fafe1788542cb123a339392a6c7605.
  - Slot10 reads d014f9a8c9ee2589e13f0cc8b6630ca6.
- Ignored start: during EXPAND of the FIPS key, pulse start with key_in=0 → schedule unchanged; slot10 still reads d014f9a8c9ee2589e13f0cc8b6630ca6 at E0+10.
- Re-key from READY: start with key_in=000102030405060708090a0b0c0d0e0f.
  - key_ready drops on the accepting edge and returns 10 cycles later.
  - Slot10 reads 13111d7fe3944a17f307a78b4d2b30c5.
- Read port:
  - Descending addresses 10..0 with rd_en held 1 return each slot one cycle after its address.
  - rd_addr=12 returns 0.
  - rd_en=0 holds rd_data.
  - Same-edge read of slot r while slot r is written returns the old value.
- Reset at E0+5: assert reset=0 during EXPAND, release, then start the FIPS key again → full correct schedule after 10 cycles; no residue from the aborted run.
